jt49_sdm_dac: RTL and testbench

JT49_SDM_DAC -- requirements
Module: jt49_sdm_dac

---
 rtl/jt49_sdm_dac.sv | 138 +++++++++++++
 tb/tb_jt49_sdm_dac.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_sdm_dac.sv
// ============================================================================
// Module   : jt49_sdm_dac
// Brief    : Interpolating second-order sigma-delta DAC for JT49 audio samples
// Revision : 1.0
// ============================================================================
`default_nettype none

module jt49_sdm_dac #(
    parameter int SHIFT = 5,
    parameter int IW1   = 12,
    parameter int IW2   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic signed [7:0] din,
    output logic              dout,
    output logic              ramp
);

    localparam int               C_CW       = 8 + SHIFT;
    localparam logic [SHIFT-1:0] C_CNT_LOAD = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic signed [C_CW-1:0] r_cur, w_cur_nxt;
    logic signed [7:0]      r_tgt, w_tgt_nxt;
    logic signed [8:0]      r_step, w_step_nxt;
    logic [SHIFT-1:0]       r_cnt, w_cnt_nxt;
    logic                   r_ramp;
    logic signed [IW1-1:0]  r_i1, w_i1_nxt;
    logic signed [IW2-1:0]  r_i2, w_i2_nxt;
    logic                   r_dout;

    logic signed [7:0]      w_x;
    logic                   w_frac_nz;
    logic signed [8:0]      w_step_new;
    logic signed [C_CW:0]   w_cur_sum;
    logic signed [C_CW-1:0] w_cur_step;
    logic signed [C_CW-1:0] w_tgt_full;
    logic signed [8:0]      w_fb;
    logic signed [IW1+1:0]  w_i1_sum;
    logic signed [IW2+1:0]  w_i2_sum;

    assign w_x       = r_cur[C_CW-1:SHIFT];
    assign w_frac_nz = |r_cur[SHIFT-1:0];

    // floor((din*2^S - cur) / 2^S) equals din - ceil(cur / 2^S)
    assign w_step_new = $signed({din[7], din}) - $signed({w_x[7], w_x})
                      - $signed({8'd0, w_frac_nz});

    // A floor-rounded negative step can overshoot a target near full scale
    assign w_cur_sum  = $signed({r_cur[C_CW-1], r_cur})
                      + $signed({{(C_CW-8){r_step[8]}}, r_step});
    assign w_cur_step = (w_cur_sum[C_CW] != w_cur_sum[C_CW-1])
                      ? {w_cur_sum[C_CW], {(C_CW-1){~w_cur_sum[C_CW]}}}
                      : w_cur_sum[C_CW-1:0];
    assign w_tgt_full = {r_tgt, {SHIFT{1'b0}}};

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_tgt_nxt   = r_tgt;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        if (cen) begin
            w_tgt_nxt   = din;
            w_step_nxt  = w_step_new;
            w_cnt_nxt   = C_CNT_LOAD;
            w_state_nxt = ST_RAMP;
        end else if (r_state == ST_RAMP) begin
            if (r_cnt != '0) begin
                w_cur_nxt = w_cur_step;
                w_cnt_nxt = r_cnt - SHIFT'(1);
            end else begin
                w_cur_nxt   = w_tgt_full;
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_tgt   <= '0;
            r_step  <= '0;
            r_cnt   <= '0;
            r_ramp  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_tgt   <= w_tgt_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ramp  <= (w_state_nxt == ST_RAMP);
        end
    end

    assign w_fb = r_dout ? 9'sd128 : -9'sd128;

    assign w_i1_sum = $signed({{2{r_i1[IW1-1]}}, r_i1})
                    + $signed({{(IW1-6){w_x[7]}}, w_x})
                    - $signed({{(IW1-7){w_fb[8]}}, w_fb});
    assign w_i2_sum = $signed({{2{r_i2[IW2-1]}}, r_i2})
                    + $signed({{(IW2+2-IW1){r_i1[IW1-1]}}, r_i1})
                    - $signed({{(IW2-7){w_fb[8]}}, w_fb});

    // Clamp when the guard bits disagree with the destination sign bit
    assign w_i1_nxt = (w_i1_sum[IW1+1:IW1-1] == 3'b000 || w_i1_sum[IW1+1:IW1-1] == 3'b111)
                    ? w_i1_sum[IW1-1:0]
                    : {w_i1_sum[IW1+1], {(IW1-1){~w_i1_sum[IW1+1]}}};
    assign w_i2_nxt = (w_i2_sum[IW2+1:IW2-1] == 3'b000 || w_i2_sum[IW2+1:IW2-1] == 3'b111)
                    ? w_i2_sum[IW2-1:0]
                    : {w_i2_sum[IW2+1], {(IW2-1){~w_i2_sum[IW2+1]}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i1   <= '0;
            r_i2   <= '0;
            r_dout <= 1'b0;
        end else begin
            r_i1   <= w_i1_nxt;
            r_i2   <= w_i2_nxt;
            r_dout <= ~w_i2_nxt[IW2-1];
        end
    end

    assign dout = r_dout;
    assign ramp = r_ramp;

endmodule

`default_nettype wire

// File: tb/tb_jt49_sdm_dac.sv
// ============================================================================
// Module   : tb_jt49_sdm_dac
// Brief    : Scoreboard bench for jt49_sdm_dac (ramp, modulator, reset)
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_jt49_sdm_dac;

    localparam int SHIFT = 5;
    localparam int IW1   = 12;
    localparam int IW2   = 16;
    localparam int CW    = 8 + SHIFT;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              cen   = 1'b0;
    logic signed [7:0] din   = 8'sd0;
    logic              dout;
    logic              ramp;

    jt49_sdm_dac #(.SHIFT(SHIFT), .IW1(IW1), .IW2(IW2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cen  (cen),
        .din  (din),
        .dout (dout),
        .ramp (ramp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic longint dut_x();
        return longint'(dut.r_cur) >>> SHIFT;
    endfunction

    typedef struct {
        longint ramp;
        longint cur;
        longint dout;
        longint i1;
        longint i2;
    } exp_t;

    exp_t   sb[$];
    exp_t   e;
    longint m_cur, m_step, m_cnt, m_i1, m_i2, m_tgt, m_ramp, m_dout;
    longint m_x, m_fb, m_i1n, m_i2n;

    // Reference model: one update per rising edge, expectation pushed for the next falling edge
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cur = 0; m_step = 0; m_cnt = 0; m_i1 = 0; m_i2 = 0;
            m_tgt = 0; m_ramp = 0; m_dout = 0;
            sb.delete();
        end else begin
            m_x   = m_cur >>> SHIFT;
            m_fb  = (m_dout != 0) ? 128 : -128;
            m_i1n = sat(m_i1 + m_x - m_fb, IW1);
            m_i2n = sat(m_i2 + m_i1 - m_fb, IW2);
            m_i1  = m_i1n;
            m_i2  = m_i2n;
            m_dout = (m_i2n >= 0) ? 1 : 0;
            if (cen) begin
                m_tgt  = longint'(din);
                m_step = ((longint'(din) <<< SHIFT) - m_cur) >>> SHIFT;
                m_cnt  = (1 << SHIFT) - 1;
                m_ramp = 1;
            end else if (m_ramp != 0) begin
                if (m_cnt != 0) begin
                    m_cur = sat(m_cur + m_step, CW);
                    m_cnt = m_cnt - 1;
                end else begin
                    m_cur  = m_tgt <<< SHIFT;
                    m_ramp = 0;
                end
            end
            sb.push_back('{m_ramp, m_cur, m_dout, m_i1, m_i2});
        end
    end

    initial forever begin
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("sb_ramp", longint'(ramp), e.ramp);
            check_val("sb_cur",  longint'(dut.r_cur), e.cur);
            check_val("sb_dout", longint'(dout), e.dout);
            check_val("sb_i1",   longint'(dut.r_i1), e.i1);
            check_val("sb_i2",   longint'(dut.r_i2), e.i2);
        end
    end

    int     ones_cnt, ramp_cnt, wraps;
    longint min_x, prev_i1, prev_i2;

    function automatic bit wrapped(input longint a, input longint b, input int w);
        longint d;
        d = (a > b) ? a - b : b - a;
        return ((a < 0) != (b < 0)) && (d > (longint'(1) <<< (w - 1)));
    endfunction

    task automatic run(input int n);
        ones_cnt = 0;
        ramp_cnt = 0;
        min_x    = 1000;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ones_cnt += int'(dout);
            ramp_cnt += int'(ramp);
            if (dut_x() < min_x) min_x = dut_x();
            if (wrapped(prev_i1, longint'(dut.r_i1), IW1)) wraps++;
            if (wrapped(prev_i2, longint'(dut.r_i2), IW2)) wraps++;
            prev_i1 = longint'(dut.r_i1);
            prev_i2 = longint'(dut.r_i2);
        end
    endtask

    task automatic pulse_cen(input logic signed [7:0] d);
        cen = 1'b1;
        din = d;
        @(negedge clk);
        cen = 1'b0;
        din = ~d;
    endtask

    initial begin
        wraps   = 0;
        prev_i1 = 0;
        prev_i2 = 0;

        repeat (3) @(negedge clk);
        check_val("rst_ramp", longint'(ramp), 0);
        check_val("rst_dout", longint'(dout), 0);
        check_val("rst_cur",  longint'(dut.r_cur), 0);
        check_val("rst_i1",   longint'(dut.r_i1), 0);
        check_val("rst_i2",   longint'(dut.r_i2), 0);

        // Idle at x=0: half density, no ramp
        rst_n = 1'b1;
        din   = 8'sd0;
        run(256);
        check_val($sformatf("idle_ones=%0d in[126:130]", ones_cnt),
                  longint'(ones_cnt >= 126 && ones_cnt <= 130), 1);
        check_val("idle_ramp_cnt", ramp_cnt, 0);
        din = -8'sd100;
        run(32);
        check_val("din_ignored_x", dut_x(), 0);

        // Ramp 0 -> 64
        pulse_cen(8'sd64);
        check_val("r64_ramp_start", longint'(ramp), 1);
        run(16);
        check_val("r64_x_mid", dut_x(), 32);
        check_val("r64_ramp_cnt_a", ramp_cnt, 16);
        run(16);
        check_val("r64_ramp_cnt_b", ramp_cnt, 15);
        check_val("r64_x_end", dut_x(), 64);
        check_val("r64_ramp_end", longint'(ramp), 0);
        run(64);
        run(1024);
        check_val($sformatf("dens64_ones=%0d in[760:776]", ones_cnt),
                  longint'(ones_cnt >= 760 && ones_cnt <= 776), 1);

        // cen on the first edge after reset release, then a mid-ramp retarget
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cen   = 1'b1;
        din   = 8'sd64;
        @(negedge clk);
        cen = 1'b0;
        din = -8'sd1;
        check_val("cen_at_release", longint'(ramp), 1);
        run(10);
        check_val("retgt_x_start", dut_x(), 20);
        pulse_cen(-8'sd64);
        check_val("retgt_ramp", longint'(ramp), 1);
        run(32);
        check_val("retgt_ramp_cnt", ramp_cnt, 31);
        check_val("retgt_x_end", dut_x(), -64);
        check_val("retgt_ramp_end", longint'(ramp), 0);
        check_val($sformatf("retgt_min_x=%0d below -64", min_x), longint'(min_x < -64), 0);

        // Full-scale levels
        wraps = 0;
        pulse_cen(-8'sd128);
        run(1033);
        run(256);
        check_val($sformatf("neg_fs_ones=%0d above 1", ones_cnt), longint'(ones_cnt > 1), 0);
        pulse_cen(8'sd127);
        run(1033);
        run(256);
        check_val($sformatf("pos_fs_ones=%0d below 254", ones_cnt), longint'(ones_cnt < 254), 0);
        check_val("int_wraps", wraps, 0);

        // Short asynchronous reset in the middle of a ramp
        pulse_cen(8'sd64);
        run(5);
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_cur",  longint'(dut.r_cur), 0);
        check_val("arst_ramp", longint'(ramp), 0);
        check_val("arst_dout", longint'(dout), 0);
        check_val("arst_i1",   longint'(dut.r_i1), 0);
        check_val("arst_i2",   longint'(dut.r_i2), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pulse_cen(8'sd64);
        run(16);
        check_val("arst_ramp_from0", dut_x(), 32);
        run(20);

        // Random retargets, checked by the scoreboard every cycle
        for (int k = 0; k < 400; k++) begin
            cen = ($urandom_range(0, 15) == 0);
            din = 8'($urandom);
            @(negedge clk);
        end
        cen = 1'b0;
        run(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
